// File: rtl/spi_i2c_cmd_ctrl_pkg.sv
// Shared types and constants for the SPI-to-I2C command controller.
// Holds the command FSM encoding, STATUS bit layout and the default poll address.
package spi_i2c_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_REQ  = 2'd1,
    C_RUN  = 2'd2
  } cmd_state_e;

  localparam int unsigned ST_PENDING = 7;
  localparam int unsigned ST_ACKERR  = 6;
  localparam int unsigned ST_RDAVAIL = 5;
  localparam int unsigned ST_OVERRUN = 4;

  localparam logic [6:0] NOP_ADDR_DEFAULT = 7'h7F;

  function automatic logic [7:0] pack_status(input logic pending, input logic ack_err,
                                             input logic rd_avail, input logic overrun);
    logic [7:0] s;
    s             = '0;
    s[ST_PENDING] = pending;
    s[ST_ACKERR]  = ack_err;
    s[ST_RDAVAIL] = rd_avail;
    s[ST_OVERRUN] = overrun;
    return s;
  endfunction

endpackage

// File: rtl/spi_i2c_cmd_ctrl_shifter.sv
// SPI mode-0 slave shifter: input synchronisers, edge detection, bit/byte
// counting, MOSI deserialiser and MISO serialiser with parallel load.
module spi_i2c_cmd_ctrl_shifter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic [7:0] load_byte,
  output logic       spi_miso,
  output logic       byte_done,
  output logic [1:0] byte_idx,
  output logic [7:0] rx_byte,
  output logic       frame_end
);

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_hist, cs_hist;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise, in_frame;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_in;
  logic [7:0]             shift_out;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist;
  assign sck_fall = ~sck_s & sck_hist;
  assign cs_fall  = ~cs_s & cs_hist;
  assign cs_rise  = cs_s & ~cs_hist;
  assign in_frame = ~cs_s & ~cs_hist;
  assign spi_miso = shift_out[7];

  // byte_idx counts completed bytes in the frame (saturating at 3), so it is
  // also the index of the byte currently being shifted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_hist  <= 1'b0;
      cs_hist   <= 1'b1;
      bit_cnt   <= 3'd0;
      byte_idx  <= 2'd0;
      shift_in  <= 7'd0;
      shift_out <= 8'd0;
      rx_byte   <= 8'd0;
      byte_done <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_hist  <= sck_s;
      cs_hist   <= cs_s;
      byte_done <= 1'b0;
      frame_end <= 1'b0;
      if (cs_fall) begin
        bit_cnt   <= 3'd0;
        byte_idx  <= 2'd0;
        shift_out <= load_byte;
      end else if (cs_rise) begin
        bit_cnt   <= 3'd0;
        byte_idx  <= 2'd0;
        frame_end <= 1'b1;
      end else if (in_frame) begin
        if (sck_rise) begin
          shift_in <= {shift_in[5:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            rx_byte   <= {shift_in, mosi_s};
            if (byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
          end
        end else if (sck_fall) begin
          // The first fall after a completed byte presents the next byte's MSB.
          shift_out <= (bit_cnt == 3'd0) ? load_byte : {shift_out[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_i2c_cmd_ctrl.sv
// SPI-slave command front end for the I2C master: decodes header/data frames,
// launches I2C transactions and reports status and read data back on MISO.
module spi_i2c_cmd_ctrl
  import spi_i2c_cmd_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  NOP_ADDR    = NOP_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_tx_data,
  output logic       i2c_tx_valid,
  input  logic       i2c_tx_ready,
  input  logic [7:0] i2c_rx_data,
  input  logic       i2c_rx_valid,
  input  logic       i2c_busy,
  input  logic       i2c_ack_err
);

  logic       byte_done, frame_end;
  logic [1:0] byte_idx;
  logic [7:0] rx_byte, load_byte, status;

  cmd_state_e state;
  logic       pending, ack_err, rd_avail, overrun;
  logic [7:0] rd_data, hdr;
  logic       hdr_valid, busy_q;

  logic       hdr_done, data_done, launch, launch_rw;
  logic [6:0] launch_addr;
  logic [7:0] launch_data;

  spi_i2c_cmd_ctrl_shifter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .load_byte (load_byte),
    .spi_miso  (spi_miso),
    .byte_done (byte_done),
    .byte_idx  (byte_idx),
    .rx_byte   (rx_byte),
    .frame_end (frame_end)
  );

  assign status    = pack_status(pending, ack_err, rd_avail, overrun);
  assign hdr_done  = byte_done && (byte_idx == 2'd1);
  assign data_done = byte_done && (byte_idx == 2'd2);

  always_comb begin
    case (byte_idx)
      2'd0:    load_byte = status;
      2'd1:    load_byte = rd_data;
      default: load_byte = 8'd0;
    endcase
  end

  // Reads launch off the header; writes wait for the data byte of the same frame.
  always_comb begin
    launch      = 1'b0;
    launch_addr = rx_byte[7:1];
    launch_rw   = rx_byte[0];
    launch_data = i2c_tx_data;
    if (hdr_done && rx_byte[0] && (rx_byte[7:1] != NOP_ADDR)) begin
      launch = 1'b1;
    end else if (data_done && hdr_valid && !hdr[0] && (hdr[7:1] != NOP_ADDR)) begin
      launch      = 1'b1;
      launch_addr = hdr[7:1];
      launch_rw   = 1'b0;
      launch_data = rx_byte;
    end
  end

  // Clears are written before sets so a coincident set wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= C_IDLE;
      pending      <= 1'b0;
      ack_err      <= 1'b0;
      rd_avail     <= 1'b0;
      overrun      <= 1'b0;
      rd_data      <= 8'd0;
      hdr          <= 8'd0;
      hdr_valid    <= 1'b0;
      busy_q       <= 1'b0;
      i2c_addr     <= 7'd0;
      i2c_rw       <= 1'b0;
      i2c_tx_data  <= 8'd0;
      i2c_tx_valid <= 1'b0;
    end else begin
      busy_q <= i2c_busy;
      if (frame_end) hdr_valid <= 1'b0;
      if (hdr_done) begin
        hdr       <= rx_byte;
        hdr_valid <= 1'b1;
        ack_err   <= 1'b0;
        overrun   <= 1'b0;
      end
      if (data_done) rd_avail <= 1'b0;

      if (launch) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          i2c_addr     <= launch_addr;
          i2c_rw       <= launch_rw;
          i2c_tx_data  <= launch_data;
          i2c_tx_valid <= 1'b1;
          pending      <= 1'b1;
          state        <= C_REQ;
        end
      end

      case (state)
        C_REQ: begin
          // A consumed byte also proves the master has started.
          if (i2c_busy || i2c_tx_ready) begin
            i2c_tx_valid <= 1'b0;
            state        <= C_RUN;
          end
        end
        C_RUN: begin
          if (i2c_rx_valid) begin
            rd_data  <= i2c_rx_data;
            rd_avail <= 1'b1;
          end
          if (busy_q && !i2c_busy) begin
            if (i2c_ack_err) ack_err <= 1'b1;
            pending <= 1'b0;
            state   <= C_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_i2c_cmd_ctrl.sv
// Scoreboard bench for spi_i2c_cmd_ctrl: directed SPI frames, a behavioural
// I2C master model, and monitors comparing MISO bytes and launched commands.
module tb_spi_i2c_cmd_ctrl;

  localparam int HALF = 80;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso;
  logic [6:0] i2c_addr;
  logic       i2c_rw;
  logic [7:0] i2c_tx_data;
  logic       i2c_tx_valid;
  logic       i2c_tx_ready = 1'b0;
  logic [7:0] i2c_rx_data = 8'd0;
  logic       i2c_rx_valid = 1'b0;
  logic       i2c_busy = 1'b0;
  logic       i2c_ack_err = 1'b0;

  int n_cmp = 0, n_fail = 0;
  logic [7:0] exp_miso[$];
  logic [7:0] act_miso[$];
  txn_t       exp_tx[$];

  int         master_hold = 5;
  logic [7:0] master_rx = 8'd0;
  logic       master_nack = 1'b0;
  logic       master_stall = 1'b0;
  int         done_cnt = 0;
  int         exp_done = 0;

  spi_i2c_cmd_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_sck      (spi_sck),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .i2c_addr     (i2c_addr),
    .i2c_rw       (i2c_rw),
    .i2c_tx_data  (i2c_tx_data),
    .i2c_tx_valid (i2c_tx_valid),
    .i2c_tx_ready (i2c_tx_ready),
    .i2c_rx_data  (i2c_rx_data),
    .i2c_rx_valid (i2c_rx_valid),
    .i2c_busy     (i2c_busy),
    .i2c_ack_err  (i2c_ack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired, got nothing, expected event", name);
  endtask

  // Mode-0 host: MOSI changes on SCK fall, MISO sampled just before SCK rise.
  task automatic spi_frame(input logic [15:0] data, input int nbits);
    logic [7:0] got;
    got      = 8'd0;
    spi_cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[15-i];
      #(HALF);
      got     = {got[6:0], spi_miso};
      spi_sck = 1'b1;
      #(HALF);
      spi_sck = 1'b0;
      if (i % 8 == 7) act_miso.push_back(got);
    end
    #(HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #(2 * HALF);
  endtask

  task automatic expect_tx(input logic [6:0] a, input logic rw, input logic [7:0] d);
    txn_t t;
    t.addr = a;
    t.rw   = rw;
    t.data = d;
    exp_tx.push_back(t);
  endtask

  task automatic wait_done();
    int n;
    exp_done++;
    n = 0;
    while (done_cnt < exp_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < exp_done) begin
      fail_now("i2c transaction completion");
      done_cnt = exp_done;
    end
    repeat (10) @(negedge clk);
  endtask

  // MISO scoreboard monitor.
  initial begin
    logic [7:0] a, e;
    forever begin
      @(negedge clk);
      while (act_miso.size() > 0) begin
        a = act_miso.pop_front();
        if (exp_miso.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL miso unexpected byte: got 0x%0h, expected none", a);
        end else begin
          e = exp_miso.pop_front();
          check("miso byte", 32'(a), 32'(e));
        end
      end
    end
  end

  // Command monitor: every tx_valid rise must match the next expected command.
  initial begin
    logic tx_prev;
    txn_t e;
    tx_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_tx_valid && !tx_prev) begin
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected tx_valid: got addr 0x%0h rw %0d, expected none",
                   i2c_addr, i2c_rw);
        end else begin
          e = exp_tx.pop_front();
          check("i2c_addr", 32'(i2c_addr), 32'(e.addr));
          check("i2c_rw", 32'(i2c_rw), 32'(e.rw));
          if (!e.rw) check("i2c_tx_data", 32'(i2c_tx_data), 32'(e.data));
        end
      end
      tx_prev = i2c_tx_valid;
    end
  end

  // Behavioural I2C master.
  initial begin
    logic rw;
    forever begin
      @(negedge clk);
      if (i2c_tx_valid && !i2c_busy && !master_stall && rst_n) begin
        rw = i2c_rw;
        @(negedge clk);
        i2c_busy    = 1'b1;
        i2c_ack_err = 1'b0;
        check("tx_valid as busy rises", 32'(i2c_tx_valid), 32'd1);
        @(negedge clk);
        check("tx_valid one cycle after busy", 32'(i2c_tx_valid), 32'd0);
        if (!rw) begin
          i2c_tx_ready = 1'b1;
          @(negedge clk);
          i2c_tx_ready = 1'b0;
        end
        repeat (master_hold) @(negedge clk);
        if (rw) begin
          i2c_rx_data  = master_rx;
          i2c_rx_valid = 1'b1;
          @(negedge clk);
          i2c_rx_valid = 1'b0;
        end
        repeat (4) @(negedge clk);
        i2c_busy    = 1'b0;
        i2c_ack_err = master_nack;
        done_cnt++;
      end
    end
  end

  initial begin
    int n;
    repeat (5) @(negedge clk);
    check("reset tx_valid", 32'(i2c_tx_valid), 32'd0);
    check("reset i2c_addr", 32'(i2c_addr), 32'd0);
    check("reset i2c_tx_data", 32'(i2c_tx_data), 32'd0);
    check("reset spi_miso", 32'(spi_miso), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0x5C to 0x50, then poll.
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    expect_tx(7'h50, 1'b0, 8'h5C);
    spi_frame(16'hA05C, 16);
    wait_done();
    exp_miso.push_back(8'h00);
    spi_frame(16'hFE00, 8);

    // Read from 0x50 returning 0x3C; rd_avail clears after the second poll byte.
    master_rx = 8'h3C;
    exp_miso.push_back(8'h00);
    expect_tx(7'h50, 1'b1, 8'h00);
    spi_frame(16'hA100, 8);
    wait_done();
    exp_miso.push_back(8'h20); exp_miso.push_back(8'h3C);
    spi_frame(16'hFE00, 16);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h3C);
    spi_frame(16'hFE00, 16);

    // NACK sets ack_err, cleared by the first poll header.
    master_nack = 1'b1;
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h3C);
    expect_tx(7'h50, 1'b0, 8'h77);
    spi_frame(16'hA077, 16);
    wait_done();
    master_nack = 1'b0;
    exp_miso.push_back(8'h40);
    spi_frame(16'hFE00, 8);
    exp_miso.push_back(8'h00);
    spi_frame(16'hFE00, 8);

    // Overrun: writes issued while a long read is in flight are dropped.
    master_hold = 2000;
    master_rx   = 8'h5A;
    exp_miso.push_back(8'h00);
    expect_tx(7'h50, 1'b1, 8'h00);
    spi_frame(16'hA100, 8);
    exp_miso.push_back(8'h80); exp_miso.push_back(8'h3C);
    spi_frame(16'hA011, 16);
    exp_miso.push_back(8'h90);
    spi_frame(16'hFE00, 8);
    exp_miso.push_back(8'h80); exp_miso.push_back(8'h3C);
    spi_frame(16'hA022, 16);
    wait_done();
    master_hold = 5;
    exp_miso.push_back(8'h30); exp_miso.push_back(8'h5A);
    spi_frame(16'hFE00, 16);

    // Aborted frames launch nothing; the following frame still decodes.
    spi_frame(16'hA100, 5);
    exp_miso.push_back(8'h00);
    spi_frame(16'hA000, 8);
    repeat (200) @(negedge clk);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h5A);
    expect_tx(7'h50, 1'b0, 8'h33);
    spi_frame(16'hA033, 16);
    wait_done();

    // Reset while the request is still outstanding.
    master_stall = 1'b1;
    exp_miso.push_back(8'h00);
    expect_tx(7'h50, 1'b1, 8'h00);
    spi_frame(16'hA100, 8);
    n = 0;
    while (!i2c_tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!i2c_tx_valid) fail_now("tx_valid before reset");
    spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    check("miso shows pending before reset", 32'(spi_miso), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("tx_valid after reset", 32'(i2c_tx_valid), 32'd0);
    check("spi_miso after reset", 32'(spi_miso), 32'd0);
    spi_cs_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    master_stall = 1'b0;
    repeat (5) @(negedge clk);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    spi_frame(16'hFE00, 16);

    repeat (20) @(negedge clk);
    check("miso expectations drained", 32'(exp_miso.size()), 32'd0);
    check("tx expectations drained", 32'(exp_tx.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
